// File: rtl/func_sequencer_pkg.sv
// func_sequencer shared definitions: FSM encoding and default sizes.
// Used by func_sequencer and seq_prog_ram.
package func_sequencer_pkg;

  localparam int DEF_FUNC_W     = 25;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_STATE_W    = 5;
  localparam int DEF_IDLE_STATE = 0;
  localparam int DEF_REG_SEL_W  = 3;
  localparam int DEF_TIMEOUT    = 255;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_IDLE = 3'd3,
    S_NEXT      = 3'd4,
    S_ERR       = 3'd5
  } seq_state_t;

endpackage

// File: rtl/seq_prog_ram.sv
// Program store for func_sequencer: DEPTH x FUNC_W words.
// Synchronous write, combinational read, contents survive reset.
module seq_prog_ram
  import func_sequencer_pkg::*;
#(
  parameter int FUNC_W = DEF_FUNC_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [FUNC_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [FUNC_W-1:0]        rdata
);

  logic [FUNC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/func_sequencer.sv
// Steps a stored program of function words through a processor handshake.
// Define SEQ_LOOP_EN to repeat the program until reset or timeout.
module func_sequencer
  import func_sequencer_pkg::*;
#(
  parameter int FUNC_W     = DEF_FUNC_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int STATE_W    = DEF_STATE_W,
  parameter int IDLE_STATE = DEF_IDLE_STATE,
  parameter int REG_SEL_W  = DEF_REG_SEL_W,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [FUNC_W-1:0]        load_data,
  input  logic [$clog2(DEPTH):0]   prog_len,
  input  logic                     start,
  input  logic [STATE_W-1:0]       cur_state,
  output logic [FUNC_W-1:0]        func,
  output logic                     new_func,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic [REG_SEL_W-1:0]     reg_dis,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  seq_state_t state, state_n;

  logic [PW-1:0]        pc_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [FUNC_W-1:0]    func_n;
  logic                 new_func_n;
  logic                 done_n;
  logic                 terr_n;
  logic [REG_SEL_W-1:0] reg_dis_n;
  logic [FUNC_W-1:0]    rd_word;
  logic [LW-1:0]        len_eff;
  logic [PW-1:0]        last_pc;
  logic                 we;
  logic                 cnt_hit;
  logic                 proc_idle;

  assign busy = (state != S_IDLE) && (state != S_ERR);
  assign we   = load_en && !busy;

  // Out-of-range lengths run the whole store.
  assign len_eff = (prog_len == '0 || prog_len > LW'(DEPTH))
                 ? LW'(DEPTH) : prog_len;
  assign last_pc = PW'(len_eff - LW'(1));

  assign cnt_hit   = (cnt + CW'(1)) == CW'(TIMEOUT);
  assign proc_idle = cur_state == STATE_W'(IDLE_STATE);

  seq_prog_ram #(
    .FUNC_W (FUNC_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc),
    .rdata (rd_word)
  );

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    cnt_n      = cnt;
    func_n     = func;
    new_func_n = 1'b0;
    done_n     = 1'b0;
    terr_n     = timeout_err;
    reg_dis_n  = reg_dis;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          pc_n    = '0;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        func_n     = rd_word;
        new_func_n = 1'b1;
        cnt_n      = '0;
        state_n    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!proc_idle) begin
          cnt_n   = '0;
          state_n = S_WAIT_IDLE;
        end else if (cnt_hit) begin
          terr_n  = 1'b1;
          state_n = S_ERR;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (proc_idle) begin
          state_n = S_NEXT;
        end else if (cnt_hit) begin
          terr_n  = 1'b1;
          state_n = S_ERR;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_NEXT: begin
        if (pc == last_pc) begin
          done_n    = 1'b1;
          reg_dis_n = reg_dis + REG_SEL_W'(1);
`ifdef SEQ_LOOP_EN
          pc_n      = '0;
          state_n   = S_ISSUE;
`else
          state_n   = S_IDLE;
`endif
        end else begin
          pc_n    = pc + PW'(1);
          state_n = S_ISSUE;
        end
      end
      S_ERR: begin
        state_n = S_ERR;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      cnt         <= '0;
      func        <= '0;
      new_func    <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      reg_dis     <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      cnt         <= cnt_n;
      func        <= func_n;
      new_func    <= new_func_n;
      done        <= done_n;
      timeout_err <= terr_n;
      reg_dis     <= reg_dis_n;
    end
  end

endmodule

// File: tb/tb_func_sequencer.sv
// Scoreboard bench for func_sequencer with a simple processor model.
// Issues and done pulses are checked by a monitor against queued expectations.
module tb_func_sequencer;

  localparam int FUNC_W    = 25;
  localparam int DEPTH     = 16;
  localparam int STATE_W   = 5;
  localparam int REG_SEL_W = 3;
  localparam int TIMEOUT   = 8;
`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic                 clk;
  logic                 reset;
  logic                 load_en;
  logic [3:0]           load_addr;
  logic [FUNC_W-1:0]    load_data;
  logic [4:0]           prog_len;
  logic                 start;
  logic [STATE_W-1:0]   cur_state;
  logic [FUNC_W-1:0]    func;
  logic                 new_func;
  logic [3:0]           pc;
  logic [REG_SEL_W-1:0] reg_dis;
  logic                 busy;
  logic                 done;
  logic                 timeout_err;

  func_sequencer #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .prog_len    (prog_len),
    .start       (start),
    .cur_state   (cur_state),
    .func        (func),
    .new_func    (new_func),
    .pc          (pc),
    .reg_dis     (reg_dis),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [FUNC_W-1:0] w;
    logic [3:0]        p;
  } iss_t;

  iss_t              exp_q[$];
  logic [2:0]        done_q[$];
  logic [FUNC_W-1:0] shadow [DEPTH];
  iss_t              mon_e;
  logic [2:0]        mon_d;
  int                tests = 0;
  int                fails = 0;
  int                tmr   = 0;
  bit                proc_en = 1'b1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Processor: leaves idle ~2 cycles after an issue, busy for 4 cycles.
  always @(negedge clk) begin
    if (reset) tmr = 0;
    else if (proc_en && new_func) tmr = 1;
    else if (tmr != 0) tmr++;
    if (tmr == 6) tmr = 0;
    cur_state = (tmr >= 2 && tmr <= 5) ? 5'd3 : 5'd0;
  end

  always @(negedge clk) begin
    if (new_func) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_issue: got func %0h expected none", func);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_func", 32'(func), 32'(mon_e.w));
        check("issue_pc", 32'(pc), 32'(mon_e.p));
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got reg_dis %0d expected none", reg_dis);
      end else begin
        mon_d = done_q.pop_front();
        check("done_reg_dis", 32'(reg_dis), 32'(mon_d));
        check("done_busy", 32'(busy), 32'(LOOP));
      end
    end
  end

  task automatic load(int a, logic [FUNC_W-1:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = 4'(a);
    load_data = d;
    shadow[a] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_run(int n, int dis);
    for (int i = 0; i < n; i++) exp_q.push_back({shadow[i], 4'(i)});
    done_q.push_back(3'(dis));
  endtask

  task automatic wait_done(int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL run_done: got no done expected one within %0d cycles", budget);
    end
    check("issues_left", 32'(exp_q.size()), 0);
  endtask

  task automatic reset_vals(string tag);
    check({tag, "_pc"}, 32'(pc), 0);
    check({tag, "_func"}, 32'(func), 0);
    check({tag, "_new_func"}, 32'(new_func), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_terr"}, 32'(timeout_err), 0);
    check({tag, "_reg_dis"}, 32'(reg_dis), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    done_q.delete();
    reset_vals("rst");
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected one");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    reset     = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    prog_len  = 5'd3;
    start     = 1'b0;
    cur_state = '0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    repeat (3) @(negedge clk);
    reset_vals("init");
    reset = 1'b0;

    load(0, 25'h0000001);
    load(1, 25'h0ABCDEF);
    load(2, 25'h1FFFFFF);

`ifndef SEQ_LOOP_EN
    // Three-word run, hand-written expectations.
    exp_q.push_back({25'h0000001, 4'd0});
    exp_q.push_back({25'h0ABCDEF, 4'd1});
    exp_q.push_back({25'h1FFFFFF, 4'd2});
    done_q.push_back(3'd1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lat_cycle1_new_func", 32'(new_func), 0);
    check("busy_in_run", 32'(busy), 1);
    @(negedge clk);
    check("lat_cycle2_new_func", 32'(new_func), 1);
    wait_done(200);
    @(negedge clk);
    check("run1_busy_end", 32'(busy), 0);
    check("run1_reg_dis", 32'(reg_dis), 1);
    repeat (8) @(negedge clk);

    // Abort one cycle after the second issue.
    push_run(3, 2);
    pulse_start();
    n = 0;
    for (k = 0; k < 200 && n < 2; k++) begin
      @(negedge clk);
      if (new_func) n++;
    end
    check("abort_saw_two", 32'(n), 2);
    do_reset();
    repeat (12) @(negedge clk);
    check("abort_no_done_reg", 32'(reg_dis), 0);
    push_run(3, 1);
    pulse_start();
    wait_done(200);
    repeat (8) @(negedge clk);

    // Same-cycle load and start, then a load ignored while busy.
    exp_q.push_back({25'h0000155, 4'd0});
    exp_q.push_back({25'h0ABCDEF, 4'd1});
    exp_q.push_back({25'h1FFFFFF, 4'd2});
    done_q.push_back(3'd2);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = 4'd0;
    load_data = 25'h0000155;
    start     = 1'b1;
    shadow[0] = 25'h0000155;
    @(negedge clk);
    load_en = 1'b0;
    start   = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_at_load", 32'(busy), 1);
    load_en   = 1'b1;
    load_addr = 4'd1;
    load_data = 25'h0000000;
    @(negedge clk);
    load_en = 1'b0;
    wait_done(200);
    repeat (8) @(negedge clk);
    exp_q.push_back({25'h0000155, 4'd0});
    exp_q.push_back({25'h0ABCDEF, 4'd1});
    exp_q.push_back({25'h1FFFFFF, 4'd2});
    done_q.push_back(3'd3);
    pulse_start();
    wait_done(200);
    repeat (8) @(negedge clk);

    // prog_len 0 runs all 16 slots.
    for (int i = 3; i < DEPTH; i++) load(i, 25'(i * 32'h10101));
    prog_len = 5'd0;
    push_run(DEPTH, 4);
    pulse_start();
    wait_done(400);
    check("full_pc_end", 32'(pc), 15);
    repeat (8) @(negedge clk);

    // Processor never leaves idle: timeout after 8 wait cycles.
    proc_en  = 1'b0;
    prog_len = 5'd1;
    exp_q.push_back({shadow[0], 4'd0});
    pulse_start();
    for (k = 0; k < 20 && !new_func; k++) @(negedge clk);
    check("to_issue_seen", 32'(new_func), 1);
    for (k = 0; k < 50 && !timeout_err; k++) @(negedge clk);
    check("to_cycles", 32'(k), 8);
    check("to_flag", 32'(timeout_err), 1);
    check("to_busy", 32'(busy), 0);
    pulse_start();
    repeat (10) @(negedge clk);
    check("to_start_ignored", 32'(busy), 0);
    check("to_sticky", 32'(timeout_err), 1);
    proc_en = 1'b1;
    do_reset();
`else
    // Looping two-word program; nine wraps then reset.
    prog_len = 5'd2;
    for (int r = 0; r < 9; r++) begin
      exp_q.push_back({shadow[0], 4'd0});
      exp_q.push_back({shadow[1], 4'd1});
      done_q.push_back(3'(r + 1));
    end
    exp_q.push_back({shadow[0], 4'd0});
    exp_q.push_back({shadow[1], 4'd1});
    pulse_start();
    for (k = 0; k < 600 && done_q.size() != 0; k++) @(negedge clk);
    check("loop_dones_left", 32'(done_q.size()), 0);
    check("loop_busy", 32'(busy), 1);
    check("loop_reg_dis", 32'(reg_dis), 1);
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
